instr_loader: RTL and testbench
===============================

# instr_loader

Writable instruction store for the 9-bit processor: it accepts a stream of 9-bit machine-code words over a valid/ready handshake and writes them into an internal 2**D-deep program memory, starting at address 0. While loading, it holds the core. Afterwards, it serves the fetch stage through a combinational read port indexed by the program counter. It replaces the file-initialised instruction ROM when a program is downloaded at run time, for example from a testbench or a host link.

## Interface
- D, 10, address width; memory depth is 2**D words of 9 bits
- Clk  input  1  rising-edge clock
- Reset_n  input  1  asynchronous, active-low reset
- start  input  1  one-cycle request to begin a load; honoured only in IDLE
- len  input  D+1  number of words to load (0..2**D); sampled on the cycle start is honoured
- in_valid  input  1  in_data holds a word
- in_data  input  9  machine-code word
- in_ready  output  1  loader accepts a word this cycle
- prog_ctr  input  D  fetch address
- mach_code  output  9  word at core[prog_ctr], combinational
- cpu_hold  output  1  high whenever the state is not IDLE; the core must stall
- done  output  1  one-cycle pulse when a load completes
- checksum  output  9  XOR of all words accepted in the current or most recent load

## Operation
- States: IDLE, LOAD, DONE. The state is registered.
- IDLE:
  - start=1 and len!=0 → LOAD. Capture len, clear the word counter, write address and checksum.
  - start=1 and len==0 → DONE. Clear checksum; no writes.
  - start=0 → stay in IDLE.
- LOAD:
  - in_ready=1.
  - When in_valid && in_ready: core[waddr] <= in_data, waddr+1, count+1, checksum ^= in_data.
  - When the accepted word is number len (count == len-1 before increment) → DONE.
  - in_valid low → stay in LOAD with no change; there is no timeout.
  - start is ignored.
- DONE: done=1 for exactly one cycle, then → IDLE. start is ignored.
- in_ready is driven only from the registered state (in_ready = state==LOAD), with no combinational path from in_valid.
- The counter and write address are D+1 bits wide. len=2**D fills the whole memory, and the write address never wraps within a load.
- Memory contents are not cleared by reset or by start. Words not written by a load keep their previous values.
- mach_code = core[prog_ctr] at all times, including during LOAD. The fetch side is read-only and has no enable.

## Timing
- Reset (Reset_n low, asynchronous):
  - state=IDLE, in_ready=0, cpu_hold=0, done=0, checksum=0, counter=0, write address=0.
  - Memory is untouched.
- Reset mid-load: the load is abandoned immediately. Words already written stay in memory and no done pulse is produced.
- start honoured at edge T → in_ready=1 and cpu_hold=1 in the cycle after T.
- A word transferred at edge E is visible on mach_code (when prog_ctr addresses it) and in checksum after E.
- Last word accepted at edge E → the DONE state in the cycle after E: done=1, cpu_hold=1, in_ready=0.
- One cycle later: IDLE, done=0, cpu_hold=0.
- len=0: start at edge T → done=1 in cycle T+1, then IDLE.
- Throughput: one word per cycle when in_valid is held high. A load of N words takes N cycles of LOAD plus one cycle of DONE.
- start asserted in the same cycle as the last transfer, or during DONE, is ignored. A new load requires start in IDLE.

## Test plan
- Reset: hold Reset_n=0 mid-cycle with random inputs → in_ready=0, cpu_hold=0, done=0, checksum=0 immediately. Deassert and stay in IDLE.
- Basic load: start with len=4, stream 9'h1A5, 9'h003, 9'h100, 9'h0FF back-to-back → four transfers, done one cycle after the last, checksum=9'h059. Reading prog_ctr 0..3 returns the words; address 4 is unchanged.
- Bubbles: same load with in_valid low for 3 cycles between words 2 and 3 → no extra writes, identical memory and checksum, done delayed by 3 cycles.
- Boundaries:
  - len=0 → done pulse with no in_ready cycle.
  - D=3, len=8 → addresses 0..7 all written, no wrap.
  - A second load with len=2 overwrites only addresses 0..1, and checksum restarts.
- Reset after 2 of 5 words → back to IDLE with no done pulse. Addresses 0..1 hold the new words and addresses 2..4 the old ones. A following start with len=5 completes normally.
- Ignored start: pulse start during LOAD and during DONE → len is not re-sampled, the counter is not reset, and the load finishes with the original length.

Source files
------------

// File: rtl/instr_loader.sv
// instr_loader: writable 9-bit instruction store, loaded over valid/ready, read by fetch.
// Latency: start honoured -> in_ready next cycle; last word accepted -> done next cycle; fetch read is combinational.
// Backpressure: in_ready is high only in LOAD and comes from the registered state; in_valid low simply stalls the load.
// Ports:
//   Clk, Reset_n          clock, asynchronous active-low reset
//   start, len            load request (honoured in IDLE only) and word count 0..2**D
//   in_valid/in_ready     word handshake; in_data is the 9-bit word
//   prog_ctr/mach_code    fetch address and combinational instruction word
//   cpu_hold              high whenever not IDLE
//   done                  one-cycle pulse when a load completes
//   checksum              XOR of words accepted in the current or most recent load
module instr_loader #(
  parameter int D = 10
) (
  input  logic         Clk,
  input  logic         Reset_n,
  input  logic         start,
  input  logic [D:0]   len,
  input  logic         in_valid,
  input  logic [8:0]   in_data,
  output logic         in_ready,
  input  logic [D-1:0] prog_ctr,
  output logic [8:0]   mach_code,
  output logic         cpu_hold,
  output logic         done,
  output logic [8:0]   checksum
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state;
  logic [D:0] len_q;
  logic [D:0] count;
  logic [D:0] waddr;
  logic [8:0] core [2**D];

  // Memory deliberately has no reset: contents survive reset and new loads.
  // A reset asserted mid-load forces state to IDLE at once, which stops writes.
  always_ff @(posedge Clk) begin
    if (state == LOAD && in_valid) begin
      core[waddr[D-1:0]] <= in_data;
    end
  end

  assign mach_code = core[prog_ctr];

  // Control FSM. in_ready/cpu_hold/done are registered copies of the next
  // state decode so they line up exactly with the state they describe.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state    <= IDLE;
      len_q    <= '0;
      count    <= '0;
      waddr    <= '0;
      checksum <= '0;
      in_ready <= 1'b0;
      cpu_hold <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            checksum <= '0;
            cpu_hold <= 1'b1;
            if (len != '0) begin
              state    <= LOAD;
              len_q    <= len;
              count    <= '0;
              waddr    <= '0;
              in_ready <= 1'b1;
              done     <= 1'b0;
            end else begin
              // Empty load goes straight to the completion pulse.
              state    <= DONE;
              in_ready <= 1'b0;
              done     <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (in_valid) begin
            waddr    <= waddr + 1'b1;
            count    <= count + 1'b1;
            checksum <= checksum ^ in_data;
            // Compare before increment: this transfer is word number len_q.
            if (count == len_q - 1'b1) begin
              state    <= DONE;
              in_ready <= 1'b0;
              done     <= 1'b1;
            end
          end
        end
        DONE: begin
          state    <= IDLE;
          done     <= 1'b0;
          cpu_hold <= 1'b0;
          in_ready <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          done     <= 1'b0;
          cpu_hold <= 1'b0;
          in_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_loader.sv
// Directed bench for instr_loader built with a small (D=3, 8-word) store so
// that full-memory loads are cheap. Inputs change 1 time unit after the rising
// edge and outputs are checked at that point too.
module tb_instr_loader;

  localparam int D = 3;

  logic         Clk;
  logic         Reset_n;
  logic         start;
  logic [D:0]   len;
  logic         in_valid;
  logic [8:0]   in_data;
  logic         in_ready;
  logic [D-1:0] prog_ctr;
  logic [8:0]   mach_code;
  logic         cpu_hold;
  logic         done;
  logic [8:0]   checksum;

  int vectors;
  int miscompares;

  logic [8:0] pat [8];

  instr_loader #(.D(D)) dut (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .start     (start),
    .len       (len),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .prog_ctr  (prog_ctr),
    .mach_code (mach_code),
    .cpu_hold  (cpu_hold),
    .done      (done),
    .checksum  (checksum)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic word(input logic [8:0] d);
    in_valid = 1'b1;
    in_data  = d;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [D-1:0] a, input logic [8:0] exp);
    prog_ctr = a;
    #1;
    chk(tag, mach_code, exp);
  endtask

  task automatic begin_load(input logic [D:0] n);
    start = 1'b1;
    len   = n;
    tick();
    start = 1'b0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    pat[0] = 9'h101; pat[1] = 9'h102; pat[2] = 9'h104; pat[3] = 9'h108;
    pat[4] = 9'h110; pat[5] = 9'h120; pat[6] = 9'h140; pat[7] = 9'h180;

    // ---- Reset asserted mid-cycle with random inputs ----
    Reset_n  = 1'b1;
    start    = 1'($urandom);
    len      = 4'($urandom);
    in_valid = 1'($urandom);
    in_data  = 9'($urandom);
    prog_ctr = '0;
    #2 Reset_n = 1'b0;
    #1;
    chk("rst_in_ready", {8'd0, in_ready}, 9'd0);
    chk("rst_cpu_hold", {8'd0, cpu_hold}, 9'd0);
    chk("rst_done", {8'd0, done}, 9'd0);
    chk("rst_checksum", checksum, 9'd0);
    tick();
    tick();
    start    = 1'b0;
    in_valid = 1'b0;
    #3 Reset_n = 1'b1;
    tick();
    tick();
    chk("post_rst_idle_hold", {8'd0, cpu_hold}, 9'd0);
    chk("post_rst_idle_rdy", {8'd0, in_ready}, 9'd0);

    // ---- Full-depth load: len = 2**D, no wrap ----
    begin_load(4'd8);
    chk("full_start_rdy", {8'd0, in_ready}, 9'd1);
    chk("full_start_hold", {8'd0, cpu_hold}, 9'd1);
    for (int i = 0; i < 8; i++) word(pat[i]);
    chk("full_done", {8'd0, done}, 9'd1);
    chk("full_done_rdy", {8'd0, in_ready}, 9'd0);
    chk("full_done_hold", {8'd0, cpu_hold}, 9'd1);
    chk("full_checksum", checksum, 9'h0FF);
    tick();
    chk("full_after_done", {8'd0, done}, 9'd0);
    chk("full_after_hold", {8'd0, cpu_hold}, 9'd0);
    for (int i = 0; i < 8; i++) rd($sformatf("full_mem%0d", i), 3'(i), pat[i]);

    // ---- Basic load of four words back-to-back ----
    begin_load(4'd4);
    word(9'h1A5);
    word(9'h003);
    word(9'h100);
    chk("basic_cs_partial", checksum, 9'h0A6);
    chk("basic_no_early_done", {8'd0, done}, 9'd0);
    rd("basic_live_read", 3'd0, 9'h1A5);
    word(9'h0FF);
    chk("basic_done", {8'd0, done}, 9'd1);
    chk("basic_checksum", checksum, 9'h059);
    tick();
    chk("basic_idle", {8'd0, cpu_hold}, 9'd0);
    rd("basic_mem0", 3'd0, 9'h1A5);
    rd("basic_mem1", 3'd1, 9'h003);
    rd("basic_mem2", 3'd2, 9'h100);
    rd("basic_mem3", 3'd3, 9'h0FF);
    rd("basic_mem4_kept", 3'd4, 9'h110);

    // ---- Same load with a 3-cycle bubble after word 2 ----
    begin_load(4'd4);
    word(9'h1A5);
    word(9'h003);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bubble_rdy", {8'd0, in_ready}, 9'd1);
      chk("bubble_done", {8'd0, done}, 9'd0);
      chk("bubble_cs", checksum, 9'h1A6);
    end
    word(9'h100);
    word(9'h0FF);
    chk("bubble_final_done", {8'd0, done}, 9'd1);
    chk("bubble_checksum", checksum, 9'h059);
    tick();
    rd("bubble_mem2", 3'd2, 9'h100);
    rd("bubble_mem4_kept", 3'd4, 9'h110);

    // ---- len = 0: done pulse without any in_ready cycle ----
    begin_load(4'd0);
    chk("len0_done", {8'd0, done}, 9'd1);
    chk("len0_rdy", {8'd0, in_ready}, 9'd0);
    chk("len0_hold", {8'd0, cpu_hold}, 9'd1);
    chk("len0_checksum", checksum, 9'h000);
    tick();
    chk("len0_after_done", {8'd0, done}, 9'd0);
    chk("len0_after_hold", {8'd0, cpu_hold}, 9'd0);

    // ---- Second load of two words overwrites only 0..1 ----
    begin_load(4'd2);
    word(9'h0AA);
    word(9'h033);
    chk("two_done", {8'd0, done}, 9'd1);
    chk("two_checksum", checksum, 9'h099);
    tick();
    rd("two_mem0", 3'd0, 9'h0AA);
    rd("two_mem1", 3'd1, 9'h033);
    rd("two_mem2_kept", 3'd2, 9'h100);
    rd("two_mem3_kept", 3'd3, 9'h0FF);

    // ---- Reset after 2 of 5 words ----
    begin_load(4'd5);
    word(9'h1E1);
    word(9'h1E2);
    in_valid = 1'b1;
    in_data  = 9'h1E3;
    #2 Reset_n = 1'b0;
    #1;
    chk("abort_rdy", {8'd0, in_ready}, 9'd0);
    chk("abort_hold", {8'd0, cpu_hold}, 9'd0);
    chk("abort_cs", checksum, 9'h000);
    in_valid = 1'b0;
    tick();
    #2 Reset_n = 1'b1;
    tick();
    chk("abort_no_done", {8'd0, done}, 9'd0);
    chk("abort_idle", {8'd0, cpu_hold}, 9'd0);
    rd("abort_mem0", 3'd0, 9'h1E1);
    rd("abort_mem1", 3'd1, 9'h1E2);
    rd("abort_mem2_old", 3'd2, 9'h100);
    rd("abort_mem3_old", 3'd3, 9'h0FF);
    rd("abort_mem4_old", 3'd4, 9'h110);
    begin_load(4'd5);
    word(9'h001);
    word(9'h002);
    word(9'h004);
    word(9'h008);
    chk("reload_not_done", {8'd0, done}, 9'd0);
    word(9'h010);
    chk("reload_done", {8'd0, done}, 9'd1);
    chk("reload_checksum", checksum, 9'h01F);
    tick();
    rd("reload_mem4", 3'd4, 9'h010);

    // ---- start pulses during LOAD and DONE are ignored ----
    begin_load(4'd3);
    word(9'h0C0);
    start = 1'b1;
    len   = 4'd7;
    word(9'h00C);
    chk("ign_still_load", {8'd0, in_ready}, 9'd1);
    word(9'h003);
    chk("ign_done_orig_len", {8'd0, done}, 9'd1);
    chk("ign_checksum", checksum, 9'h0CF);
    start = 1'b1;
    len   = 4'd5;
    tick();
    start = 1'b0;
    chk("ign_done_start_hold", {8'd0, cpu_hold}, 9'd0);
    chk("ign_done_start_rdy", {8'd0, in_ready}, 9'd0);
    tick();
    chk("ign_stay_idle", {8'd0, cpu_hold}, 9'd0);
    chk("ign_cs_kept", checksum, 9'h0CF);
    rd("ign_mem2", 3'd2, 9'h003);
    rd("ign_mem3_old", 3'd3, 9'h008);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
